// File: rtl/decode_queue.sv
// RV32I decode queue: DEPTH-entry {instr, pc} FIFO with combinational decode of the head entry.
// Latency: a push in cycle N is visible at the outputs in cycle N+1; decode adds no register stage.
// Backpressure: in_ready = count < DEPTH (no pass-through when full); the head holds while out_ready is low.
// Optional: DECODE_QUEUE_ILLEGAL_CHK_EN enables out_illegal and masks the usage flags of illegal opcodes.
module decode_queue #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [6:0]                 out_opcode,
    output logic [2:0]                 out_funct3,
    output logic [6:0]                 out_funct7,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic [31:0]                out_imm,
    output logic                       out_rs1_used,
    output logic                       out_rs2_used,
    output logic                       out_rd_we,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CONE = CW'(1);
    localparam logic [PW-1:0] PONE = PW'(1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [31:0]         instr_q [DEPTH];
    logic [31:0]         instr_d [DEPTH];
    logic [PC_WIDTH-1:0] pc_q    [DEPTH];
    logic [PC_WIDTH-1:0] pc_d    [DEPTH];
    logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                push, pop;

    assign in_ready  = (count_q < FULL);
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            // Storage is left as-is; only the bookkeeping is cleared.
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                instr_d[wptr_q] = in_instr;
                pc_d[wptr_q]    = in_pc;
                wptr_d          = wptr_q + PONE;
            end
            if (pop) begin
                rptr_d = rptr_q + PONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CONE;
                2'b01:   count_d = count_q - CONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    logic [31:0] ins;
    logic        rs1_raw, rs2_raw, rd_raw, illegal;

    assign ins        = instr_q[rptr_q];
    assign out_pc     = pc_q[rptr_q];
    assign out_opcode = ins[6:0];
    assign out_funct3 = ins[14:12];
    assign out_funct7 = ins[31:25];
    assign out_rs1    = ins[19:15];
    assign out_rs2    = ins[24:20];
    assign out_rd     = ins[11:7];

    always_comb begin
        out_imm = 32'h0;
        rs1_raw = 1'b0;
        rs2_raw = 1'b0;
        rd_raw  = 1'b0;
        case (ins[6:0])
            OP_LUI, OP_AUIPC: begin
                out_imm = {ins[31:12], 12'h000};
                rd_raw  = 1'b1;
            end
            OP_JAL: begin
                out_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                rd_raw  = 1'b1;
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                out_imm = {{20{ins[31]}}, ins[31:20]};
                rs1_raw = 1'b1;
                rd_raw  = 1'b1;
            end
            OP_SYSTEM: begin
                out_imm = {{20{ins[31]}}, ins[31:20]};
                rd_raw  = 1'b1;
            end
            OP_STORE: begin
                out_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                rs1_raw = 1'b1;
                rs2_raw = 1'b1;
            end
            OP_BRANCH: begin
                out_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                rs1_raw = 1'b1;
                rs2_raw = 1'b1;
            end
            OP_OP: begin
                rs1_raw = 1'b1;
                rs2_raw = 1'b1;
                rd_raw  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef DECODE_QUEUE_ILLEGAL_CHK_EN
    logic legal_op;
    always_comb begin
        legal_op = 1'b0;
        case (ins[6:0])
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM: legal_op = 1'b1;
            default: legal_op = 1'b0;
        endcase
    end
    assign illegal = out_valid && !legal_op;
`else
    assign illegal = 1'b0;
`endif

    assign out_illegal  = illegal;
    assign out_rs1_used = out_valid && !illegal && rs1_raw;
    assign out_rs2_used = out_valid && !illegal && rs2_raw;
    assign out_rd_we    = out_valid && !illegal && rd_raw && (ins[11:7] != 5'd0);
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: reset, decode fields, full/backpressure, wrap streaming, flush/reset priority.
module tb_decode_queue;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_rs1_used, out_rs2_used, out_rd_we, out_illegal;
    logic [2:0]  count;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(4), .PC_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used), .out_rd_we(out_rd_we),
        .out_illegal(out_illegal), .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    localparam logic [31:0] ADDI = 32'hFFF08293;
    localparam logic [31:0] BEQ  = 32'hFE208EE3;
    localparam logic [31:0] SW   = 32'h0020A423;
    localparam logic [31:0] LUI0 = 32'h12345037;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_instr = ADDI; in_pc = 32'h0000_0ABC;
        #1;
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0;

        // Reset state
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_imm", out_imm, 32'h0);
        chk("rst_opcode", 32'(out_opcode), 32'h0);

        // addi x5,x1,-1
        push_one(ADDI, 32'h100);
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_imm", out_imm, 32'hFFFF_FFFF);
        chk("addi_rs1", 32'(out_rs1), 32'd1);
        chk("addi_rd", 32'(out_rd), 32'd5);
        chk("addi_flags", {29'd0, out_rs1_used, out_rs2_used, out_rd_we}, 32'b101);
        chk("addi_pc", out_pc, 32'h100);
        chk("addi_opc", 32'(out_opcode), 32'h13);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("addi_popped", 32'(count), 32'd0);
        chk("empty_rd_we", 32'(out_rd_we), 32'd0);

        // Fill to DEPTH, then a push coinciding with a pop is rejected
        for (int i = 0; i < 4; i++) push_one(ADDI, 32'h200 + 32'(4 * i));
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_hold_pc", out_pc, 32'h200);
        in_valid = 1'b1; in_pc = 32'h300; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("full_pop_count", 32'(count), 32'd3);
        chk("full_pop_head", out_pc, 32'h204);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("drain_pc", out_pc, 32'h204 + 32'(4 * i));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(count), 32'd0);

        // Immediate formats
        push_one(BEQ, 32'h10);
        push_one(SW, 32'h14);
        push_one(LUI0, 32'h18);
        chk("beq_imm", out_imm, 32'hFFFF_FFFC);
        chk("beq_regs", {22'd0, out_rs1, out_rs2}, {22'd0, 5'd1, 5'd2});
        chk("beq_flags", {29'd0, out_rs1_used, out_rs2_used, out_rd_we}, 32'b110);
        out_ready = 1'b1;
        tick();
        chk("sw_imm", out_imm, 32'h0000_0008);
        chk("sw_funct3", 32'(out_funct3), 32'd2);
        chk("sw_flags", {29'd0, out_rs1_used, out_rs2_used, out_rd_we}, 32'b110);
        tick();
        chk("lui_imm", out_imm, 32'h1234_5000);
        chk("lui_rd_we", 32'(out_rd_we), 32'd0);
        tick();
        out_ready = 1'b0;

        // Streaming at count=2 across the pointer wrap
        push_one(ADDI, 32'h400);
        push_one(ADDI, 32'h404);
        out_ready = 1'b1; in_valid = 1'b1; in_instr = ADDI;
        for (int k = 0; k < 10; k++) begin
            in_pc = 32'h408 + 32'(4 * k);
            chk("stream_pc", out_pc, 32'h400 + 32'(4 * k));
            chk("stream_count", 32'(count), 32'd2);
            tick();
        end
        in_valid = 1'b0;
        chk("stream_tail0", out_pc, 32'h428);
        tick();
        chk("stream_tail1", out_pc, 32'h42C);
        tick();
        out_ready = 1'b0;
        chk("stream_empty", 32'(count), 32'd0);

        // Flush with pending push
        push_one(ADDI, 32'h500);
        push_one(ADDI, 32'h504);
        push_one(ADDI, 32'h508);
        chk("pre_flush_count", 32'(count), 32'd3);
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h50C;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_rs1_used", 32'(out_rs1_used), 32'd0);
        push_one(ADDI, 32'h600);
        chk("post_flush_pc", out_pc, 32'h600);
        chk("post_flush_count", 32'(count), 32'd1);
        push_one(ADDI, 32'h604);
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        chk("rstflush_count", 32'(count), 32'd0);
        chk("rstflush_ready", 32'(in_ready), 32'd1);
        chk("rstflush_pc", out_pc, 32'h0);

        // All-zero word
        push_one(32'h0000_0000, 32'h700);
        chk("zero_valid", 32'(out_valid), 32'd1);
`ifdef DECODE_QUEUE_ILLEGAL_CHK_EN
        chk("zero_illegal", 32'(out_illegal), 32'd1);
`else
        chk("zero_illegal", 32'(out_illegal), 32'd0);
`endif
        chk("zero_rd_we", 32'(out_rd_we), 32'd0);
        chk("zero_imm", out_imm, 32'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Buffered, handshaked RV32I decode stage between fetch and issue.
- Accepts raw instruction words with their PC into a DEPTH-entry FIFO.
- Decodes the head entry into register fields, a single format-selected immediate and control hints.
- Presents the result with valid/ready backpressure.
- Generalises the combinational field splitter: adds buffering, flush, opcode-driven immediate select and register-usage flags.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- PC_WIDTH, 32, width of the PC carried alongside each instruction.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous queue clear (branch mispredict/trap).
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  queue can accept this cycle.
- in_instr  input  32  raw instruction word.
- in_pc  input  PC_WIDTH  PC of in_instr.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes head this cycle.
- out_pc  output  PC_WIDTH  PC of head.
- out_opcode  output  7  instr[6:0].
- out_funct3  output  3  instr[14:12].
- out_funct7  output  7  instr[31:25].
- out_rs1  output  5  instr[19:15].
- out_rs2  output  5  instr[24:20].
- out_rd  output  5  instr[11:7].
- out_imm  output  32  sign-extended immediate selected by opcode.
- out_rs1_used  output  1  instruction reads rs1.
- out_rs2_used  output  1  instruction reads rs2.
- out_rd_we  output  1  instruction writes a nonzero rd.
- out_illegal  output  1  head opcode is not a legal RV32I opcode.
- count  output  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Storage: DEPTH entries of {instr, pc}, with write pointer, read pointer and count. Pointers wrap modulo DEPTH.
- Push: when in_valid && in_ready. Pop: when out_valid && out_ready.
- in_ready = (count < DEPTH). There is no pass-through when full, even if a pop occurs in the same cycle.
- out_valid = (count != 0).
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Latency: an instruction pushed in cycle N is visible at the outputs in cycle N+1 at the earliest. Decode is combinational from the head entry, with no extra register stage.
- Stability: while out_valid && !out_ready, all out_* fields hold constant.
- Immediate select, by opcode (imm formats as standard RV32I; B and J have bit 0 = 0):
  - 0110111 lui, 0010111 auipc -> U-imm {instr[31:12], 12'h000}.
  - 1101111 jal -> J-imm.
  - 1100111 jalr, 0000011 load, 0010011 op-imm, 1110011 system -> I-imm.
  - 0100011 store -> S-imm.
  - 1100011 branch -> B-imm.
  - 0110011 op, 0001111 fence, all others -> 0.
- out_rs1_used = 1 for jalr, branch, load, store, op-imm, op.
- out_rs2_used = 1 for branch, store, op.
- out_rd_we = 1 for lui, auipc, jal, jalr, load, op-imm, op, system, and only when rd != 0.
- out_illegal is defined under Optional Feature. It is always gated by out_valid.
- All decode outputs are gated by out_valid:
  - out_rs1_used, out_rs2_used, out_rd_we are 0 when out_valid = 0.
  - Raw fields show the head slot contents.
- Reset:
  - count, pointers and all storage go to 0.
  - out_valid = 0, in_ready = 1, all out_* fields = 0.
  - Reset mid-stream discards all entries; an in_valid in the reset cycle is ignored.
- Flush:
  - Next cycle: count = 0, pointers = 0, out_valid = 0.
  - A push or pop in the flush cycle is discarded or ignored.
  - Storage contents are not cleared.
  - Priority order: rst > flush > push/pop.

Optional Feature:
- Macro: DECODE_QUEUE_ILLEGAL_CHK_EN.
- Defined: out_illegal = out_valid && (opcode[1:0] != 2'b11 || opcode not in {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011}).
- Defined: when out_illegal = 1, out_rd_we, out_rs1_used and out_rs2_used are forced to 0.
- Undefined: out_illegal is tied to 0, and the flags follow the opcode table only.

Test Plan:
- Reset, then push addi x5,x1,-1 (0xFFF08293, pc 0x100) -> next cycle out_valid=1, out_imm=0xFFFFFFFF, rs1=1, rd=5, rs1_used=1, rs2_used=0, rd_we=1, out_pc=0x100.
- Push DEPTH=4 words with out_ready=0 -> count=4, in_ready=0; a 5th push in the same cycle as a pop is rejected; count becomes 3.
- Push beq x1,x2,-4 (0xFE208EE3), sw x2,8(x1) (0x0020A423), lui x0,0x12345 (0x12345037) -> imm 0xFFFFFFFC / 0x00000008 / 0x12345000; the lui has rd_we=0 because rd=0.
- Streaming with continuous push+pop at count=2 for 10 cycles across the pointer wrap -> FIFO order preserved, count stays 2.
- Flush asserted with count=3 and in_valid=1 -> next cycle count=0, out_valid=0; a subsequent push appears normally. rst asserted together with flush -> reset result.
- With DECODE_QUEUE_ILLEGAL_CHK_EN, push 0x00000000 -> out_illegal=1, rd_we=0. Without the macro, out_illegal=0.
